// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared encodings for the EX-stage ALU and its mul/div engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  // Main-decoder ALU class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // R-type function field
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Multiply/divide sequencer states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mul_div_seq.sv
// ============================================================================
// mul_div_seq : iterative unsigned shift-add multiplier / restoring divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] upper;    // partial product high half / partial remainder
  logic [WIDTH-1:0] lower;    // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] operand;  // multiplicand / divisor
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] iter_upper;
  logic [WIDTH-1:0] iter_lower;

  // One iteration of whichever algorithm is active, evaluated from current registers
  always_comb begin
    mul_sum    = {1'b0, upper} + {1'b0, (lower[0] ? operand : {WIDTH{1'b0}})};
    div_shift  = {upper, lower[WIDTH-1]};
    div_diff   = div_shift - {1'b0, operand};
    div_ge     = (div_shift >= {1'b0, operand});
    iter_upper = mul_sum[WIDTH:1];
    iter_lower = {mul_sum[0], lower[WIDTH-1:1]};
    if (state == ST_DIV) begin
      iter_upper = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lower = {lower[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      upper   <= '0;
      lower   <= '0;
      operand <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_mul || start_div) begin
            state   <= start_mul ? ST_MUL : ST_DIV;
            count   <= CNT_W'(WIDTH);
            upper   <= '0;
            lower   <= a;
            operand <= b;
          end
        end
        ST_MUL, ST_DIV: begin
          upper <= iter_upper;
          lower <= iter_lower;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign idle    = (state == ST_IDLE);
  assign busy    = (state == ST_MUL) || (state == ST_DIV);
  assign done    = busy && (count == CNT_W'(1));
  assign hi_next = iter_upper;
  assign lo_next = iter_lower;

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// alu_exec_unit : EX-stage ALU with iterative MULTU/DIVU, HI/LO and stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             is_rtype;
  logic             start_mul;
  logic             start_div;
  logic             idle;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] alu_out;

  assign is_rtype  = (aluOp == ALUOP_RTYPE);
  assign start_mul = start && is_rtype && (func == FN_MULTU);
  assign start_div = start && is_rtype && (func == FN_DIVU);

  mul_div_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul_div_seq (
    .clk       (clk),
    .rst       (rst),
    .start_mul (start_mul),
    .start_div (start_div),
    .a         (a),
    .b         (b),
    .idle      (idle),
    .busy      (busy),
    .done      (done),
    .hi_next   (hi_next),
    .lo_next   (lo_next)
  );

  // The issue cycle stalls combinationally so the instruction holds in EX
  assign stall = busy || (idle && (start_mul || start_div));

  always_comb begin
    alu_out = '0;
    case (aluOp)
      ALUOP_ADD: alu_out = a + b;
      ALUOP_SUB: alu_out = a - b;
      ALUOP_AND: alu_out = a & b;
      ALUOP_RTYPE: begin
        case (func)
          FN_AND:  alu_out = a & b;
          FN_OR:   alu_out = a | b;
          FN_ADD:  alu_out = a + b;
          FN_SUB:  alu_out = a - b;
          FN_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          FN_MFHI: alu_out = hi;
          FN_MFLO: alu_out = lo;
          default: alu_out = '0;
        endcase
      end
      default: alu_out = '0;
    endcase
  end

  assign result = idle ? alu_out : '0;
  assign zero   = (result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the pipelined MIPS core. It decodes `aluOp`/`func`, evaluates single-cycle operations in the same cycle, and runs unsigned multiply and divide iteratively over WIDTH cycles. Multiply and divide results go to internal HI/LO registers, and the unit raises `stall` to freeze the pipeline while it works. It replaces the purely combinational ALU-control/ALU pair in the EX stage.

## Interface
- `WIDTH`, 32: datapath width in bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.
- `clk`  in  1: single clock.
- `rst`  in  1: reset. Synchronous to `clk` and active-high.
- `start`  in  1: a valid instruction is in EX this cycle.
- `aluOp`  in  2: main-decoder ALU class. 00 add, 01 sub, 11 and, 10 R-type.
- `func`  in  6: R-type function field.
- `a`, `b`  in  WIDTH: operands (rs, rt).
- `result`  out  WIDTH: combinational single-cycle result.
- `zero`  out  1: `result == 0`.
- `stall`  out  1: hold IF/ID/EX; combinational.
- `hi`, `lo`  out  WIDTH: architectural HI/LO registers.

## Operation
- Decode for aluOp=10:
  - 100100 AND; 100101 OR; 100000 ADD; 100010 SUB.
  - 101010 SLT: signed compare, result is 1 or 0.
  - 010000 MFHI (result=hi); 010010 MFLO (result=lo).
  - 011001 MULTU; 011011 DIVU.
- Any other func yields result 0. The output is never X.
- Add and sub wrap modulo 2^WIDTH. No overflow is detected.
- During MULTU, DIVU and all non-IDLE cycles, `result` is 0.
- Decode is valid whether or not `start` is high. `start` only gates multiply/divide issue.
- State machine:
  - IDLE → MUL or DIV when `start` is high and func is MULTU or DIVU. At that edge, latch a and b and load count=WIDTH.
  - MUL, DIV: one iteration per cycle. count decrements each cycle. On the edge where count reaches 0, write hi/lo and go to DONE.
  - DONE → IDLE unconditionally. `start` is ignored in DONE, because the same instruction is still in EX.
- MULTU: shift-add. Full 2·WIDTH-bit product; hi = upper half, lo = lower half.
- DIVU: restoring division. lo = quotient, hi = remainder.
- DIVU by zero falls out of the algorithm with no special case: lo = all ones, hi = a. It takes the same latency as any other divide.
- hi/lo change only at multiply/divide completion.
- `rst` has priority over everything:
  - state → IDLE, count → 0, hi → 0, lo → 0.
  - Any in-flight operation is discarded and hi/lo are not written.

## Timing
- Reset values: hi=0, lo=0, stall=0 (with start=0). result and zero follow the current inputs.
- Single-cycle ops: result is valid in the same cycle. stall=0.
- Multiply/divide issued in cycle t:
  - stall=1 in cycle t. This is combinational from IDLE & start & muldiv.
  - stall stays high through cycles t+1 … t+WIDTH (MUL/DIV states).
  - hi/lo are written at the end of cycle t+WIDTH.
  - Cycle t+WIDTH+1 is DONE: stall=0, and the pipeline advances at the end of that cycle.
  - Total occupancy is WIDTH+2 cycles.
- An MFHI/MFLO that follows a multiply/divide cannot reach EX before DONE has passed. It therefore always reads the updated hi/lo. No forwarding path is needed.
- Back-to-back multiply/divide: the second issues from IDLE in the cycle it enters EX.

## Structure
- Shared package `alu_pkg` holds:
  - aluOp class codes;
  - func codes (AND, OR, ADD, SUB, SLT, MFHI, MFLO, MULTU, DIVU);
  - state encoding (IDLE, MUL, DIV, DONE).
- One sub-module, `mul_div_seq`, holds the iterative engine:
  - contents: counter, partial product/remainder registers, done pulse;
  - inputs: `start_mul`, `start_div`, operands;
  - outputs: hi/lo next values plus `busy`.
- Top level holds the decode, the single-cycle ALU, the HI/LO registers and the stall logic.

## Test plan
- SLT: aluOp=10, func=101010, a=0xFFFFFFFB (−5), b=3 → result=1, zero=0, stall=0. Swapped operands → result=0, zero=1.
- MULTU then MFLO: a=0xFFFFFFFF, b=2, start=1.
  - stall is high for exactly 33 cycles, then low in DONE.
  - hi=0x00000001, lo=0xFFFFFFFE.
  - A following MFLO gives result=0xFFFFFFFE and MFHI gives 1.
- DIVU: a=100, b=7 → lo=14, hi=2 after WIDTH+1 cycles. Divide by zero with a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, same latency.
- Reset mid-op: rst on the 10th MUL cycle → next cycle state=IDLE, stall=0, hi=lo=0. A subsequent aluOp=00 add of 3+4 gives 7 in the same cycle.
- DONE guard: hold start=1 with func=MULTU continuously.
  - The operation executes once: hi/lo are written once.
  - Second issue occurs only when IDLE is entered with start=1.
  - Unknown func 111111 → result=0, zero=1.
- Parameter sweep at WIDTH=8: MULTU 0xFF×0xFF → hi=0xFE, lo=0x01. stall is high for 9 cycles.
